// File: rtl/rnn_gain_streamer.sv
// Word-serial valid/ready streamer for one RNN result (gains plus optional VAD word).
// Optional leading VAD word enabled by defining RNN_GAIN_STREAM_VAD_EN.
module rnn_gain_streamer #(
  parameter int unsigned FIXED = 32,
  parameter int unsigned NGAIN = 22
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [NGAIN*FIXED-1:0] gains,
  input  logic [FIXED-1:0]       vad,
  output logic [FIXED-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [4:0]             out_index,
  output logic                   busy,
  output logic                   overrun
);

  localparam int unsigned IDX_W = 5;
`ifdef RNN_GAIN_STREAM_VAD_EN
  localparam int unsigned FRAME_LEN = NGAIN + 1;
`else
  localparam int unsigned FRAME_LEN = NGAIN;
`endif

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FIXED-1:0]   data_q, data_d;
  logic               last_q, last_d;
  logic               ovr_q, ovr_d;
  logic [FIXED-1:0]   gain_q [NGAIN];
  logic [FIXED-1:0]   first_word;
  logic [FIXED-1:0]   nxt_word;
  logic [IDX_W-1:0]   nxt_idx;
  logic               xfer;
  logic               accept;

  assign xfer   = (state_q == SEND) && out_ready;
  assign accept = load && ((state_q == IDLE) || (xfer && last_q));

`ifdef RNN_GAIN_STREAM_VAD_EN
  logic [FIXED-1:0] vad_q;

  always_ff @(posedge clk) begin
    if (accept) vad_q <= vad;
  end

  // Stream position k carries gain k-1, so the next word is gain[idx_q].
  always_comb begin
    nxt_idx    = idx_q + IDX_W'(1);
    first_word = vad;
    nxt_word   = '0;
    if (idx_q < IDX_W'(NGAIN)) nxt_word = gain_q[idx_q];
  end
`else
  logic unused_vad;
  assign unused_vad = ^vad;

  always_comb begin
    nxt_idx    = idx_q + IDX_W'(1);
    first_word = gains[FIXED-1:0];
    nxt_word   = '0;
    if (nxt_idx < IDX_W'(NGAIN)) nxt_word = gain_q[nxt_idx];
  end
`endif

  // Frame buffer: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < NGAIN; i++) gain_q[i] <= gains[i*FIXED +: FIXED];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    ovr_d   = ovr_q;
    if (load && !accept) ovr_d = 1'b1;
    if (accept) begin
      state_d = SEND;
      idx_d   = '0;
      data_d  = first_word;
      last_d  = 1'(FRAME_LEN == 1);
    end else if (xfer) begin
      if (last_q) begin
        state_d = IDLE;
        idx_d   = '0;
        data_d  = '0;
        last_d  = 1'b0;
      end else begin
        idx_d  = nxt_idx;
        data_d = nxt_word;
        last_d = (nxt_idx == IDX_W'(FRAME_LEN - 1));
      end
    end
  end

  assign out_data  = data_q;
  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_last  = last_q;
  assign out_index = idx_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_rnn_gain_streamer.sv
// Scoreboard bench for rnn_gain_streamer; follows RNN_GAIN_STREAM_VAD_EN like the RTL.
module tb_rnn_gain_streamer;

  localparam int unsigned FIXED = 32;
  localparam int unsigned NGAIN = 22;
`ifdef RNN_GAIN_STREAM_VAD_EN
  localparam int unsigned LEN = NGAIN + 1;
  localparam bit          VAD_EN = 1'b1;
`else
  localparam int unsigned LEN = NGAIN;
  localparam bit          VAD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  i;
    logic        l;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   load;
  logic [NGAIN*FIXED-1:0] gains;
  logic [FIXED-1:0]       vad;
  logic [FIXED-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic [4:0]             out_index;
  logic                   busy;
  logic                   overrun;

  rnn_gain_streamer #(.FIXED(FIXED), .NGAIN(NGAIN)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .gains(gains), .vad(vad),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_index(out_index), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        ovr_m = 1'b0;
  logic        held_pending = 1'b0;
  exp_t        held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] base, input logic [31:0] vadv);
    exp_t e;
    for (int k = 0; k < int'(LEN); k++) begin
      if (VAD_EN) e.d = (k == 0) ? vadv : base + 32'(k - 1);
      else        e.d = base + 32'(k);
      e.i = 5'(k);
      e.l = (k == int'(LEN) - 1);
      sb.push_back(e);
    end
  endtask

  // One cycle: called at negedge, drives inputs, checks, then advances to the next negedge.
  task automatic cyc(input logic rdy, input logic ld, input logic [31:0] base, input logic [31:0] vadv);
    exp_t e;
    logic acc;
    out_ready = rdy;
    load      = ld;
    if (ld) begin
      for (int i = 0; i < int'(NGAIN); i++) gains[i*FIXED +: FIXED] = base + 32'(i);
      vad = vadv;
    end
    check("valid", 32'(out_valid), 32'(sb.size() != 0));
    check("busy", 32'(busy), 32'(sb.size() != 0));
    check("overrun", 32'(overrun), 32'(ovr_m));
    if (held_pending && out_valid) begin
      check("hold_data", out_data, held.d);
      check("hold_index", 32'(out_index), 32'(held.i));
      check("hold_last", 32'(out_last), 32'(held.l));
    end
    acc = ld && ((sb.size() == 0) || (sb.size() == 1 && rdy));
    held_pending = 1'b0;
    if (out_valid && rdy) begin
      if (sb.size() == 0) begin
        check("unexpected_word", 32'(out_index), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("data", out_data, e.d);
        check("index", 32'(out_index), 32'(e.i));
        check("last", 32'(out_last), 32'(e.l));
      end
    end else if (out_valid) begin
      held_pending = 1'b1;
      held.d = out_data;
      held.i = out_index;
      held.l = out_last;
    end
    if (ld) begin
      if (acc) push_frame(base, vadv);
      else     ovr_m = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic drain(input string tag, input bit bp);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      cyc(bp ? ((n % 4) == 0 || (n % 4) == 3) : 1'b1, 1'b0, 32'h0, 32'h0);
      n++;
    end
    check(tag, 32'(sb.size()), 32'h0);
  endtask

  task automatic check_reset_vals();
    check("rst_data", out_data, 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_last", 32'(out_last), 32'h0);
    check("rst_index", 32'(out_index), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; out_ready = 1'b0; gains = '0; vad = '0;
    @(negedge clk); @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame, ready held high, then two idle cycles.
    cyc(1'b1, 1'b1, 32'h100, 32'h1);
    drain("single_drain", 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0);

    // Backpressure 1,0,0,1 with sign-bit-heavy data.
    cyc(1'b1, 1'b1, 32'h8000_0300, 32'hDEAD_0003);
    drain("bp_drain", 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 32'h0);

    // Back-to-back: second load on the final handshake.
    cyc(1'b1, 1'b1, 32'h100, 32'h11);
    for (int n = 0; n < 100 && sb.size() > 1; n++) cyc(1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b1, 32'h200, 32'h22);
    check("b2b_index0", 32'(out_index), 32'h0);
    check("b2b_valid", 32'(out_valid), 32'h1);
    drain("b2b_drain", 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0);

    // Overrun: load at index 5 is dropped, frame continues unchanged.
    cyc(1'b1, 1'b1, 32'h400, 32'h44);
    for (int n = 0; n < 5; n++) cyc(1'b1, 1'b0, 32'h0, 32'h0);
    check("ovr_at_index", 32'(out_index), 32'h5);
    cyc(1'b1, 1'b1, 32'h500, 32'h55);
    drain("ovr_drain", 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0);

    // Reset mid-frame at index 10, then a clean frame.
    cyc(1'b1, 1'b1, 32'h600, 32'h66);
    for (int n = 0; n < 10; n++) cyc(1'b1, 1'b0, 32'h0, 32'h0);
    check("pre_rst_index", 32'(out_index), 32'hA);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    sb.delete();
    ovr_m = 1'b0;
    held_pending = 1'b0;
    cyc(1'b1, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b1, 32'h700, 32'h77);
    drain("post_rst_drain", 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
